cpu_seq_ctrl: RTL and testbench
===============================

// Module: cpu_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for the 16-bit A/D/ALU/PC datapath. A single-port memory holds
//  both instructions and data. This block fetches each instruction through that memory,
//  decodes it, arbitrates the port between fetch and M read/write, and drives the load
//  strobes for A, D, PC and memory. It also drives the ALU select. A wait-state watchdog
//  flags a hung memory.
// PARAMETERS
//  WIDTH     16  instruction/data width; bit fields below assume 16
//  MAX_WAIT  15  max consecutive not-ready cycles per memory request before bus error
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      asynchronous, active-high reset
//  mem_rdata    in   WIDTH  memory read data (instruction or M operand)
//  mem_ready    in   1      memory completes current request this cycle
//  mem_req      out  1      memory request valid
//  mem_we       out  1      1 = write (outM to M), 0 = read
//  mem_addr_sel out  1      0 = address from PC, 1 = address from A (addrM)
//  m_latch      out  1      1-cycle pulse: capture mem_rdata into ALU M-operand reg
//  ir           out  WIDTH  current instruction register
//  alu_sel      out  6      ALU function = ir[11:6]
//  alu_y_sel    out  1      ALU y input: 0 = A, 1 = M operand (ir[12])
//  alu_zr       in   1      ALU result == 0
//  alu_ng       in   1      ALU result < 0
//  a_load       out  1      load A register
//  a_src        out  1      A source: 1 = ir (A-instr), 0 = ALU result
//  d_load       out  1      load D register
//  pc_inc       out  1      PC <= PC+1
//  pc_load      out  1      PC <= A (jump)
//  retire       out  1      1-cycle pulse per completed instruction
//  bus_err      out  1      sticky watchdog error; core halted
//  state_o      out  3      FSM state encoding, debug
// BEHAVIOUR
//  Reset (async, high): state=FETCH, ir=0, wait_cnt=0, bus_err=0. While reset is high
//   every output is 0, including mem_req. The first fetch request appears in the cycle
//   reset deasserts.
//  Encodings: FETCH=0 DECODE=1 MREAD=2 EXEC=3 MWRITE=4 ERROR=7.
//  Strobes are combinational from state, ir and inputs. Registers update on the clk edge.
//  FETCH:  mem_req=1, we=0, addr_sel=0. On mem_ready: ir<=mem_rdata -> DECODE.
//  DECODE: ir[15]=0 (A-instr): a_load=1, a_src=1, pc_inc=1, retire=1 -> FETCH.
//          ir[15]=1: ir[12]=1 -> MREAD, else -> EXEC.
//  MREAD:  mem_req=1, we=0, addr_sel=1. On mem_ready: m_latch=1 -> EXEC.
//  EXEC:   ALU is valid (alu_sel, alu_y_sel stable since DECODE).
//          taken = (ir[2]&ng) | (ir[1]&zr) | (ir[0]&~ng&~zr).
//          ir[3]=1 (dest M) -> MWRITE. No commit in EXEC, so A and D stay stable and
//          addrM/outM stay valid.
//          ir[3]=0 -> commit -> FETCH.
//  MWRITE: mem_req=1, we=1, addr_sel=1. On mem_ready: commit -> FETCH.
//  commit: a_load=ir[5], a_src=0, d_load=ir[4], pc_load=taken, pc_inc=~taken,
//          retire=1, all in the same cycle.
//          Jump target is the pre-commit A value (pc_load samples A before A updates).
//  Latency (zero wait states): A-instr 2 cyc; C-instr 3; +1 with M read; +1 with M
//   write. Max 5 cycles.
//  Watchdog: wait_cnt increments each cycle mem_req=1 & mem_ready=0. It clears on any
//   completed handshake.
//   When wait_cnt==MAX_WAIT and ready is still low: go to ERROR and set bus_err=1.
//  ERROR: all strobes 0. Held until reset.
//  mem_ready while mem_req=0 is ignored.
//  ir changes only on FETCH handshake.
//  Reset mid-instruction aborts it with no commit. A partially issued write is the
//   memory's concern.
// TESTING
//  1 reset, memory 0 wait: fetch 0x0005 -> a_load=1, a_src=1, pc_inc=1 in DECODE;
//    retire 2 cycles after the first req.
//  2 ir=0xEC10 (D=A), zero wait -> EXEC cycle 3: d_load=1, pc_inc=1, no mem_req in EXEC.
//  3 ir=0xFC20 (A=M), 2 wait states in MREAD -> m_latch on 3rd MREAD cycle, a_load=1,
//    a_src=0 next cycle.
//  4 ir=0xE308 (M=D): MWRITE has we=1, addr_sel=1; A/D/PC strobes fire only with
//    mem_ready.
//  5 ir=0xE301 (D;JGT): zr=0, ng=0 -> pc_load=1, pc_inc=0; with zr=1 -> pc_inc=1,
//    pc_load=0.
//  6 mem_ready held low 15 cycles in FETCH -> 16th cycle state=ERROR, bus_err=1,
//    mem_req=0. Async reset mid-MWRITE -> outputs 0 immediately, clean FETCH after.

Source files
------------

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle instruction sequencer for the 16-bit A/D/ALU/PC datapath.
// Arbitrates a single shared memory port between instruction fetch and M
// operand read/write, decodes the instruction register and drives the
// register load strobes. A wait-state watchdog halts the core on a hung memory.
module cpu_seq_ctrl #(
    parameter int WIDTH    = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             m_latch,
    output logic [WIDTH-1:0] ir,
    output logic [5:0]       alu_sel,
    output logic             alu_y_sel,
    input  logic             alu_zr,
    input  logic             alu_ng,
    output logic             a_load,
    output logic             a_src,
    output logic             d_load,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             retire,
    output logic             bus_err,
    output logic [2:0]       state_o
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        MREAD  = 3'd2,
        EXEC   = 3'd3,
        MWRITE = 3'd4,
        ERROR  = 3'd7
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   irQ;
    logic [CNT_W-1:0]   waitCnt;
    logic               busErrQ;

    logic memActive;
    logic handshake;
    logic stall;
    logic timeout;
    logic taken;
    logic commit;

    // Memory port activity, watchdog expiry, jump condition and commit point
    always_comb begin
        memActive = (state == FETCH) || (state == MREAD) || (state == MWRITE);
        handshake = memActive && mem_ready;
        stall     = memActive && !mem_ready;
        timeout   = stall && (waitCnt == CNT_W'(MAX_WAIT));
        taken     = (irQ[2] & alu_ng) | (irQ[1] & alu_zr) | (irQ[0] & ~alu_ng & ~alu_zr);
        commit    = ((state == EXEC) && !irQ[3]) || ((state == MWRITE) && mem_ready);
    end

    // Sequencer state, instruction register, wait-state watchdog and sticky error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= FETCH;
            irQ     <= '0;
            waitCnt <= '0;
            busErrQ <= 1'b0;
        end else if (timeout) begin
            state   <= ERROR;
            busErrQ <= 1'b1;
        end else begin
            if (handshake) begin
                waitCnt <= '0;
            end else if (stall) begin
                waitCnt <= waitCnt + CNT_W'(1);
            end
            case (state)
                FETCH: begin
                    if (mem_ready) begin
                        irQ   <= mem_rdata;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    if (!irQ[15]) begin
                        state <= FETCH;
                    end else if (irQ[12]) begin
                        state <= MREAD;
                    end else begin
                        state <= EXEC;
                    end
                end
                MREAD: begin
                    if (mem_ready) begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    state <= irQ[3] ? MWRITE : FETCH;
                end
                MWRITE: begin
                    if (mem_ready) begin
                        state <= FETCH;
                    end
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state <= ERROR;
                end
            endcase
        end
    end

    // Combinational strobes from state, ir and inputs; forced low while reset is held
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        m_latch      = 1'b0;
        a_load       = 1'b0;
        a_src        = 1'b0;
        d_load       = 1'b0;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        retire       = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    mem_req = 1'b1;
                end
                DECODE: begin
                    if (!irQ[15]) begin
                        a_load = 1'b1;
                        a_src  = 1'b1;
                        pc_inc = 1'b1;
                        retire = 1'b1;
                    end
                end
                MREAD: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    m_latch      = mem_ready;
                end
                MWRITE: begin
                    mem_req      = 1'b1;
                    mem_we       = 1'b1;
                    mem_addr_sel = 1'b1;
                end
                default: begin
                end
            endcase
            // A is loaded in the same cycle PC samples it, so a jump uses the old A
            if (commit) begin
                a_load  = irQ[5];
                d_load  = irQ[4];
                pc_load = taken;
                pc_inc  = ~taken;
                retire  = 1'b1;
            end
        end
    end

    assign ir        = irQ;
    assign alu_sel   = irQ[11:6];
    assign alu_y_sel = irQ[12];
    assign bus_err   = busErrQ;
    assign state_o   = state;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Scoreboard bench for cpu_seq_ctrl: the stimulus process plays the memory and
// ALU flags, pushing the expected strobe snapshot for every cycle that must show
// a strobe; the monitor pops and compares on every cycle the DUT shows one.
module tb_cpu_seq_ctrl;

    logic        clk;
    logic        reset;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        m_latch;
    logic [15:0] ir;
    logic [5:0]  alu_sel;
    logic        alu_y_sel;
    logic        alu_zr;
    logic        alu_ng;
    logic        a_load;
    logic        a_src;
    logic        d_load;
    logic        pc_inc;
    logic        pc_load;
    logic        retire;
    logic        bus_err;
    logic [2:0]  state_o;

    cpu_seq_ctrl #(
        .WIDTH(16),
        .MAX_WAIT(15)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr_sel(mem_addr_sel),
        .m_latch(m_latch),
        .ir(ir),
        .alu_sel(alu_sel),
        .alu_y_sel(alu_y_sel),
        .alu_zr(alu_zr),
        .alu_ng(alu_ng),
        .a_load(a_load),
        .a_src(a_src),
        .d_load(d_load),
        .pc_inc(pc_inc),
        .pc_load(pc_load),
        .retire(retire),
        .bus_err(bus_err),
        .state_o(state_o)
    );

    typedef struct packed {
        logic [31:0] cyc;
        logic [2:0]  st;
        logic [15:0] irv;
        logic [5:0]  aluSel;
        logic        aluY;
        logic        req;
        logic        we;
        logic        addrSel;
        logic        mLatch;
        logic        aLoad;
        logic        aSrc;
        logic        dLoad;
        logic        pcInc;
        logic        pcLoad;
        logic        ret;
    } rec_t;

    typedef struct {
        logic [15:0] instr;
        int          fw;
        int          mw;
        logic        zr;
        logic        ng;
        logic        jmp;
    } vec_t;

    rec_t        expQ[$];
    vec_t        vecs[0:12];
    logic [31:0] cyc = '0;
    int          errors = 0;
    int          checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    function automatic rec_t mkRec(input logic [2:0] st, input logic [15:0] iv,
                                   input logic req, input logic we, input logic addrSel,
                                   input logic mLatch, input logic aLoad, input logic aSrc,
                                   input logic dLoad, input logic pcInc, input logic pcLoad,
                                   input logic ret);
        rec_t r;
        r.cyc     = cyc;
        r.st      = st;
        r.irv     = iv;
        r.aluSel  = iv[11:6];
        r.aluY    = iv[12];
        r.req     = req;
        r.we      = we;
        r.addrSel = addrSel;
        r.mLatch  = mLatch;
        r.aLoad   = aLoad;
        r.aSrc    = aSrc;
        r.dLoad   = dLoad;
        r.pcInc   = pcInc;
        r.pcLoad  = pcLoad;
        r.ret     = ret;
        return r;
    endfunction

    // Monitor: every cycle with any strobe must match the next expected snapshot
    always @(negedge clk) begin
        rec_t act;
        rec_t exp;
        if (!reset && (retire | m_latch | a_load | d_load | pc_inc | pc_load)) begin
            act.cyc     = cyc;
            act.st      = state_o;
            act.irv     = ir;
            act.aluSel  = alu_sel;
            act.aluY    = alu_y_sel;
            act.req     = mem_req;
            act.we      = mem_we;
            act.addrSel = mem_addr_sel;
            act.mLatch  = m_latch;
            act.aLoad   = a_load;
            act.aSrc    = a_src;
            act.dLoad   = d_load;
            act.pcInc   = pc_inc;
            act.pcLoad  = pc_load;
            act.ret     = retire;
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got %h, expected no strobe", act);
            end else begin
                exp = expQ.pop_front();
                if (act !== exp) begin
                    errors++;
                    $display("FAIL strobe_snapshot: got %h, expected %h", act, exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Play one instruction; mem_ready is pulsed high in DECODE/EXEC to show it is ignored
    task automatic runInstr(input vec_t v);
        alu_zr = v.zr;
        alu_ng = v.ng;
        for (int i = 0; i < v.fw; i++) begin
            mem_ready = 1'b0;
            step();
        end
        mem_ready = 1'b1;
        mem_rdata = v.instr;
        step();
        mem_ready = 1'b1;
        mem_rdata = 16'hDEAD;
        if (!v.instr[15]) begin
            expQ.push_back(mkRec(3'd1, v.instr, 0, 0, 0, 0, 1, 1, 0, 1, 0, 1));
            step();
            mem_ready = 1'b0;
            return;
        end
        step();
        if (v.instr[12]) begin
            for (int i = 0; i < v.mw; i++) begin
                mem_ready = 1'b0;
                step();
            end
            mem_ready = 1'b1;
            mem_rdata = 16'h1234;
            expQ.push_back(mkRec(3'd2, v.instr, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0));
            step();
        end
        mem_ready = 1'b1;
        mem_rdata = 16'hDEAD;
        if (!v.instr[3]) begin
            expQ.push_back(mkRec(3'd3, v.instr, 0, 0, 0, 0, v.instr[5], 0, v.instr[4],
                                 ~v.jmp, v.jmp, 1));
            step();
            mem_ready = 1'b0;
            return;
        end
        step();
        for (int i = 0; i < v.mw; i++) begin
            mem_ready = 1'b0;
            step();
        end
        mem_ready = 1'b1;
        expQ.push_back(mkRec(3'd4, v.instr, 1, 1, 1, 0, v.instr[5], 0, v.instr[4],
                             ~v.jmp, v.jmp, 1));
        step();
        mem_ready = 1'b0;
    endtask

    initial begin
        vec_t v;
        //            instr     fw mw  zr    ng    jump
        vecs[0]  = '{16'h0005, 0, 0, 1'b0, 1'b0, 1'b0};  // A=5
        vecs[1]  = '{16'hEC10, 0, 0, 1'b0, 1'b0, 1'b0};  // D=A
        vecs[2]  = '{16'hFC20, 0, 2, 1'b0, 1'b0, 1'b0};  // A=M, 2 wait states
        vecs[3]  = '{16'hE308, 1, 3, 1'b0, 1'b0, 1'b0};  // M=D, 3 wait states
        vecs[4]  = '{16'hE301, 0, 0, 1'b0, 1'b0, 1'b1};  // D;JGT positive
        vecs[5]  = '{16'hE301, 0, 0, 1'b1, 1'b0, 1'b0};  // D;JGT zero
        vecs[6]  = '{16'hE304, 0, 0, 1'b0, 1'b1, 1'b1};  // D;JLT negative
        vecs[7]  = '{16'hE302, 0, 0, 1'b1, 1'b0, 1'b1};  // D;JEQ zero
        vecs[8]  = '{16'hE302, 0, 0, 1'b0, 1'b1, 1'b0};  // D;JEQ negative
        vecs[9]  = '{16'hE307, 0, 0, 1'b0, 1'b0, 1'b1};  // D;JMP
        vecs[10] = '{16'hFC38, 1, 1, 1'b0, 1'b0, 1'b0};  // AMD=M
        vecs[11] = '{16'hE30D, 0, 0, 1'b0, 1'b1, 1'b1};  // M=D;JNE negative
        vecs[12] = '{16'h7FFF, 2, 0, 1'b0, 1'b0, 1'b0};  // A=0x7FFF

        reset     = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 16'hFFFF;
        alu_zr    = 1'b0;
        alu_ng    = 1'b0;
        step();
        step();
        check("reset_strobes",
              {21'd0, mem_req, mem_we, mem_addr_sel, m_latch, a_load, a_src, d_load,
               pc_inc, pc_load, retire, bus_err}, 32'd0);
        check("reset_ir", {16'd0, ir}, 32'd0);
        check("reset_state", {29'd0, state_o}, 32'd0);

        reset = 1'b0;
        #1;
        check("first_fetch_req", {29'd0, mem_req, mem_we, mem_addr_sel}, 32'd4);

        for (int i = 0; i < 13; i++) begin
            v = vecs[i];
            runInstr(v);
        end

        // Watchdog: 15 stalled cycles tolerated, the 16th trips the error
        mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) step();
        check("wd_before_limit", {28'd0, state_o, mem_req}, {28'd0, 3'd0, 1'b1});
        step();
        check("wd_error_state", {29'd0, state_o}, 32'd7);
        check("wd_bus_err", {30'd0, bus_err, mem_req}, 32'd2);
        mem_ready = 1'b1;
        step();
        step();
        check("error_held", {28'd0, state_o, bus_err}, {28'd0, 3'd7, 1'b1});

        // Async reset in the middle of a write clears everything at once
        reset = 1'b1;
        step();
        reset = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 16'hE308;
        step();
        mem_ready = 1'b0;
        step();
        step();
        check("in_mwrite", {28'd0, state_o, mem_we}, {28'd0, 3'd4, 1'b1});
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_outputs",
              {16'd0, 3'd0, mem_req, mem_we, mem_addr_sel, a_load, d_load, pc_inc,
               pc_load, retire, bus_err, state_o[2:1], state_o[0]}, 32'd0);
        check("async_reset_ir", {16'd0, ir}, 32'd0);
        step();
        reset = 1'b0;
        #1;
        check("clean_fetch", {28'd0, state_o, mem_req}, {28'd0, 3'd0, 1'b1});
        v = '{16'h0007, 0, 0, 1'b0, 1'b0, 1'b0};
        runInstr(v);

        step();
        step();
        check("scoreboard_drained", expQ.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
